// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : dual-thread round-robin fetch with prefix folding and redirects
// Rev 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] T0_START = 16'h0000,
  parameter logic [15:0] T1_START = 16'h0001,
  parameter logic [15:0] PC_STEP  = 16'h0002
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redir_valid,
  input  logic        redir_tid,
  input  logic [15:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        out_tid,
  output logic [3:0]  out_pre,
  output logic        out_pre_vld,
  output logic        all_stopped
);

  localparam logic [3:0]  C_OP_PRE = 4'hF;
  localparam logic [15:0] C_OP_SYS = 16'h0009;

  logic [15:0] r_pc [2];
  logic [3:0]  r_pend [2];
  logic [1:0]  r_pend_vld;
  logic [1:0]  r_stop;
  logic        r_rr;

  logic        w_has_sel;
  logic        w_sel;
  logic        w_slot;
  logic        w_adv;
  logic        w_is_pre;
  logic        w_is_sys;
  logic        w_squash;
  logic        w_sel_pend_vld;
  logic [3:0]  w_sel_pend;

  // A fetch slot exists whenever a thread is runnable and the output register is free.
  // A redirect aimed at the selected thread burns the slot: the word is dropped.
  always_comb begin
    w_has_sel      = !r_stop[r_rr] || !r_stop[~r_rr];
    w_sel          = !r_stop[r_rr] ? r_rr : ~r_rr;
    imem_addr      = w_has_sel ? r_pc[w_sel] : r_pc[r_rr];
    w_slot         = w_has_sel && (!out_valid || out_ready);
    w_adv          = w_slot && !(redir_valid && (redir_tid == w_sel));
    w_is_pre       = (imem_rdata[15:12] == C_OP_PRE);
    w_is_sys       = (imem_rdata == C_OP_SYS);
    w_squash       = redir_valid && out_valid && (out_tid == redir_tid);
    w_sel_pend_vld = r_pend_vld[w_sel];
    w_sel_pend     = r_pend[w_sel];
  end

  assign all_stopped = r_stop[0] & r_stop[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc[0]    <= T0_START;
      r_pc[1]    <= T1_START;
      r_pend[0]  <= 4'h0;
      r_pend[1]  <= 4'h0;
      r_pend_vld <= 2'b00;
      r_stop     <= 2'b00;
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (redir_valid && (redir_tid == t[0])) begin
          r_pc[t]       <= redir_pc;
          r_pend[t]     <= 4'h0;
          r_pend_vld[t] <= 1'b0;
          r_stop[t]     <= 1'b0;
        end else if (w_adv && (w_sel == t[0])) begin
          r_pc[t] <= r_pc[t] + PC_STEP;
          if (w_is_pre) begin
            r_pend[t]     <= imem_rdata[3:0];
            r_pend_vld[t] <= 1'b1;
          end else begin
            r_pend[t]     <= 4'h0;
            r_pend_vld[t] <= 1'b0;
            if (w_is_sys) begin
              r_stop[t] <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr <= 1'b0;
    end else if (w_slot) begin
      r_rr <= ~w_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_instr   <= 16'h0000;
      out_pc      <= 16'h0000;
      out_tid     <= 1'b0;
      out_pre     <= 4'h0;
      out_pre_vld <= 1'b0;
    end else if (w_adv) begin
      if (w_is_pre) begin
        out_valid <= 1'b0;
      end else begin
        out_valid   <= 1'b1;
        out_instr   <= imem_rdata;
        out_pc      <= r_pc[w_sel];
        out_tid     <= w_sel;
        out_pre     <= w_sel_pend_vld ? w_sel_pend : 4'h0;
        out_pre_vld <= w_sel_pend_vld;
      end
    end else if (out_valid && (out_ready || w_squash)) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed scenarios plus random traffic against a thread-level model
// Rev 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redir_valid = 1'b0;
  logic        redir_tid = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_tid;
  logic [3:0]  out_pre;
  logic        out_pre_vld;
  logic        all_stopped;

  logic [15:0] mem [1024];
  assign imem_rdata = mem[imem_addr[9:0]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_tid(redir_tid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_tid(out_tid), .out_pre(out_pre),
    .out_pre_vld(out_pre_vld), .all_stopped(all_stopped)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: per-thread PC, stop flag and pending prefix, plus the one-deep output slot.
  logic [15:0] m_pc [2];
  bit          m_stop [2];
  bit          m_pv [2];
  logic [3:0]  m_pend [2];
  bit          m_rr;
  bit          m_ov;
  logic [15:0] m_oi, m_op;
  bit          m_ot;
  logic [3:0]  m_opre;
  bit          m_opv;

  task automatic model_reset();
    m_pc[0] = 16'h0000; m_pc[1] = 16'h0001;
    for (int t = 0; t < 2; t++) begin
      m_stop[t] = 0; m_pv[t] = 0; m_pend[t] = 4'h0;
    end
    m_rr = 0; m_ov = 0; m_oi = 16'h0; m_op = 16'h0; m_ot = 0; m_opre = 4'h0; m_opv = 0;
  endtask

  function automatic int model_sel();
    int s = -1;
    for (int k = 0; k < 2; k++) begin
      int c = int'(m_rr) ^ k;
      if (s < 0 && !m_stop[c]) s = c;
    end
    return s;
  endfunction

  task automatic model_step(input bit rdy, input bit rv, input bit rt, input logic [15:0] rpc);
    int          s = model_sel();
    bit          slot = (s >= 0) && (!m_ov || rdy);
    logic [15:0] w;
    if (m_ov && (rdy || (rv && m_ot == rt))) m_ov = 0;
    if (slot) begin
      m_rr = (s == 0);
      if (!(rv && int'(rt) == s)) begin
        w = mem[m_pc[s][9:0]];
        if (w[15:12] == 4'hF) begin
          m_pend[s] = w[3:0];
          m_pv[s]   = 1;
        end else begin
          m_ov = 1; m_oi = w; m_op = m_pc[s]; m_ot = (s == 1);
          m_opv = m_pv[s]; m_opre = m_pv[s] ? m_pend[s] : 4'h0;
          m_pv[s] = 0;
          if (w == 16'h0009) m_stop[s] = 1;
        end
        m_pc[s] = m_pc[s] + 16'd2;
      end
    end
    if (rv) begin
      m_pc[rt] = rpc; m_pv[rt] = 0; m_stop[rt] = 0;
    end
  endtask

  task automatic compare();
    int s = model_sel();
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_instr", out_instr, m_oi);
      check("out_pc", out_pc, m_op);
      check("out_tid", out_tid, m_ot);
      check("out_pre", out_pre, m_opre);
      check("out_pre_vld", out_pre_vld, m_opv);
    end
    check("imem_addr", imem_addr, (s >= 0) ? m_pc[s] : m_pc[m_rr]);
    check("all_stopped", all_stopped, m_stop[0] && m_stop[1]);
  endtask

  task automatic cycle(input bit rdy, input bit rv, input bit rt, input logic [15:0] rpc);
    compare();
    out_ready = rdy; redir_valid = rv; redir_tid = rt; redir_pc = rpc;
    model_step(rdy, rv, rt, rpc);
    @(posedge clk);
    @(negedge clk);
    redir_valid = 1'b0;
  endtask

  task automatic mem_default();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1; out_ready = 1'b1; redir_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    // Strict alternation from reset
    mem_default(); mem[0] = 16'h8005; mem[1] = 16'h8007;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 16'h0);
    check("rst_imem_addr", imem_addr, 16'h0);
    check("rst_all_stopped", all_stopped, 0);
    cycle(1, 0, 0, 0);
    check("alt1_pc", out_pc, 16'h0); check("alt1_tid", out_tid, 0); check("alt1_instr", out_instr, 16'h8005);
    cycle(1, 0, 0, 0);
    check("alt2_pc", out_pc, 16'h1); check("alt2_tid", out_tid, 1); check("alt2_instr", out_instr, 16'h8007);
    cycle(1, 0, 0, 0);
    check("alt3_pc", out_pc, 16'h2); check("alt3_tid", out_tid, 0);

    // Prefix folding
    mem_default(); mem[0] = 16'hF003; mem[2] = 16'h6010;
    do_reset();
    cycle(1, 0, 0, 0);
    check("pre_none_valid", out_valid, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("pre_instr", out_instr, 16'h6010); check("pre_val", out_pre, 4'h3); check("pre_vld", out_pre_vld, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("pre_next_tid", out_tid, 0); check("pre_next_vld", out_pre_vld, 0);

    // Backpressure
    mem_default();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    check("stall_valid", out_valid, 1); check("stall_pc", out_pc, 16'h2);
    cycle(1, 0, 0, 0);
    check("stall_resume_pc", out_pc, 16'h3);
    cycle(1, 0, 0, 0);
    check("stall_resume2_pc", out_pc, 16'h4);

    // Redirect squashes the held instruction of the same thread
    mem_default();
    do_reset();
    repeat (5) cycle(1, 0, 0, 0);
    check("redir_held_pc", out_pc, 16'h4);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 16'h0100);
    check("redir_squash", out_valid, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("redir_new_pc", out_pc, 16'h0100); check("redir_new_tid", out_tid, 0);

    // Redirect clears a pending prefix
    mem_default(); mem[0] = 16'hF00A;
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 16'h0100);
    cycle(1, 0, 0, 0);
    check("redir_pre_pc", out_pc, 16'h0100); check("redir_pre_vld", out_pre_vld, 0);

    // sys stops both threads; redirect revives thread 1 only
    mem_default(); mem[0] = 16'h0009; mem[1] = 16'h0009;
    do_reset();
    cycle(1, 0, 0, 0);
    check("sys0_instr", out_instr, 16'h0009);
    cycle(1, 0, 0, 0);
    check("sys1_tid", out_tid, 1); check("sys_all_stopped", all_stopped, 1);
    cycle(1, 0, 0, 0);
    check("sys_drained", out_valid, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 16'h0011);
    check("sys_revive", all_stopped, 0);
    cycle(1, 0, 0, 0);
    check("sys_t1_pc", out_pc, 16'h0011); check("sys_t1_tid", out_tid, 1);
    cycle(1, 0, 0, 0);
    check("sys_t1_pc2", out_pc, 16'h0013);

    // Asynchronous reset with an instruction held and a prefix pending
    mem_default(); mem[0] = 16'hF00A;
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0); check("arst_pc", out_pc, 16'h0);
    check("arst_pre_vld", out_pre_vld, 0); check("arst_imem_addr", imem_addr, 16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cycle(1, 0, 0, 0);

    // Random traffic
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 1024; i++) begin
        int r = $urandom_range(0, 99);
        logic [15:0] w = 16'($urandom);
        if (r < 12) w[15:12] = 4'hF;
        else if (r < 15) w = 16'h0009;
        else if (w[15:12] == 4'hF) w[15:12] = 4'h2;
        mem[i] = w;
      end
      do_reset();
      for (int c = 0; c < 600; c++) begin
        bit          rdy = ($urandom_range(0, 9) < 7);
        bit          rv  = ($urandom_range(0, 9) == 0) || (m_stop[0] && m_stop[1] && $urandom_range(0, 3) == 0);
        bit          rt  = 1'($urandom);
        logic [15:0] rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom_range(0, 1023));
        cycle(rdy, rv, rt, rpc);
      end
      compare();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
